alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one combinational ALU_Shift unit between two requesters: channel 0 is the core execute FSM and channel 1 is the auxiliary/debug datapath.
- Latches the winning requester's operand bundle and drives the shared ALU from registers.
- Captures F/NZCV one cycle later into per-channel result registers.
- Sits between the CPU control FSM, the aux port and the single ALU_Shift instance.

Parameters:
DW, 32, operand/result width (A, Shift_Data, F)
SNW, 8, shift-amount width (Shift_Num)

Ports:
clk  input  1  system clock, all state on posedge
Rst_n  input  1  asynchronous active-low reset
req0  input  1  channel 0 request; held until gnt0 seen
alu_op0  input  4  channel 0 ALU_OP
shift_op0  input  3  channel 0 SHIFT_OP
a0  input  DW  channel 0 A operand
sd0  input  DW  channel 0 Shift_Data
sn0  input  SNW  channel 0 Shift_Num
cv0  input  2  channel 0 {CF,VF} carry-in flags
gnt0  output  1  one-cycle grant pulse, channel 0
done0  output  1  one-cycle completion pulse, channel 0
f0  output  DW  channel 0 result, held until next channel 0 completion
nzcv0  output  4  channel 0 flags, held likewise
req1, alu_op1, shift_op1, a1, sd1, sn1, cv1, gnt1, done1, f1, nzcv1: same as channel 0, for channel 1
ALU_OP  output  4  to shared ALU
SHIFT_OP  output  3  to shared ALU
A  output  DW  to shared ALU
Shift_Data  output  DW  to shared ALU
Shift_Num  output  SNW  to shared ALU
CF  output  1  to shared ALU
VF  output  1  to shared ALU
F_New  input  DW  combinational ALU result
NZCV_New  input  4  combinational ALU flags
busy  output  1  high while state is EXEC

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on Rst_n. All state changes on posedge clk.
- Reset values:
  - State = IDLE; last = 1 (channel 0 wins the first tie).
  - gnt0, gnt1, done0, done1 and busy = 0.
  - f0, f1, nzcv0 and nzcv1 = 0.
  - All ALU-facing outputs = 0.
- States are IDLE and EXEC. Throughput is one operation per 2 cycles.
- IDLE, no req at posedge: stay in IDLE; gnt and done = 0.
- IDLE, req0 or req1 at posedge:
  - Pick the winner. A single requester wins outright. If both request, the channel != last wins.
  - Latch the winner's alu_op/shift_op/a/sd/sn/cv into the ALU-facing registers.
  - Set gnt_winner = 1 and last = winner; go to EXEC.
- EXEC posedge:
  - Capture F_New into f_winner and NZCV_New into nzcv_winner; done_winner = 1.
  - Clear gnt; go to IDLE. req is not sampled at this edge.
- Latency: request sampled at edge k; gnt visible in cycle k..k+1; result and done visible after edge k+1.
- busy is high exactly while the state is EXEC.
- Requester rules:
  - Drop req at the edge where it sees gnt (end of EXEC).
  - A req still high in the following IDLE is a new request.
- A req deasserted before being granted has no effect. No request is ever queued.
- ALU-facing outputs hold their last latched values in IDLE; no glitch back to 0.
- The other channel's f/nzcv are never disturbed by a completion.
- Reset mid-EXEC aborts the operation: no done, all outputs return to reset values.
- Starvation bound: with both channels continuously requesting, grants strictly alternate.

Optional Feature:
Macro ALU_ARB_CORE_PRIO_EN.
- Defined: fixed priority. Channel 0 always wins when both request. last is still updated but ignored.
- Not defined: round-robin as in Behaviour.

Test Plan:
- Single channel 0 ADD: req0 with alu_op0=4'b0100, shift_op0=3'b000, sn0=0, a0=5, sd0=3 (real ALU_Shift attached) -> gnt0 one cycle after the sampling edge; done0 the next cycle; f0=8, nzcv0=4'b0000; f1/nzcv1 unchanged at 0.
- Overflow flags: channel 1 ADD, a1=32'h7FFFFFFF, sd1=1 -> f1=32'h80000000, nzcv1=4'b1001.
- Both request right after reset: req0=req1=1 held -> gnt0 first, then gnt1. Grant sequence 0,1,0,1 over 8 cycles. With ALU_ARB_CORE_PRIO_EN defined: 0,0,0,0.
- Zero result: channel 0 SUB, alu_op0=4'b0010, a0=3, sd0=3 -> f0=0, nzcv0=4'b0110. A channel 1 ADD issued afterwards leaves f0/nzcv0 unchanged.
- Reset abort: assert Rst_n=0 during EXEC of a channel 1 request -> no done1; all outputs 0 immediately. After release, the first single req0 is granted normally.
- Early drop: req1 high for less than one cycle, falling before the next posedge -> no gnt1, busy stays 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU_Shift between two requesters, round-robin on ties.
// Define ALU_ARB_CORE_PRIO_EN to give channel 0 fixed priority over channel 1 instead.
module alu_arbiter #(
    parameter int DW  = 32,
    parameter int SNW = 8
) (
    input  logic           clk,
    input  logic           Rst_n,
    // channel 0 (core execute FSM)
    input  logic           req0,
    input  logic [3:0]     alu_op0,
    input  logic [2:0]     shift_op0,
    input  logic [DW-1:0]  a0,
    input  logic [DW-1:0]  sd0,
    input  logic [SNW-1:0] sn0,
    input  logic [1:0]     cv0,
    output logic           gnt0,
    output logic           done0,
    output logic [DW-1:0]  f0,
    output logic [3:0]     nzcv0,
    // channel 1 (aux/debug datapath)
    input  logic           req1,
    input  logic [3:0]     alu_op1,
    input  logic [2:0]     shift_op1,
    input  logic [DW-1:0]  a1,
    input  logic [DW-1:0]  sd1,
    input  logic [SNW-1:0] sn1,
    input  logic [1:0]     cv1,
    output logic           gnt1,
    output logic           done1,
    output logic [DW-1:0]  f1,
    output logic [3:0]     nzcv1,
    // shared ALU_Shift
    output logic [3:0]     ALU_OP,
    output logic [2:0]     SHIFT_OP,
    output logic [DW-1:0]  A,
    output logic [DW-1:0]  Shift_Data,
    output logic [SNW-1:0] Shift_Num,
    output logic           CF,
    output logic           VF,
    input  logic [DW-1:0]  F_New,
    input  logic [3:0]     NZCV_New,
    output logic           busy
);

    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    state_t         state_reg;
    logic           last_reg;
    logic           owner_reg;
    logic [1:0]     gnt_reg;
    logic [1:0]     done_reg;
    logic [3:0]     alu_op_reg;
    logic [2:0]     shift_op_reg;
    logic [DW-1:0]  a_reg;
    logic [DW-1:0]  sd_reg;
    logic [SNW-1:0] sn_reg;
    logic [1:0]     cv_reg;
    logic [DW-1:0]  f_reg    [2];
    logic [3:0]     nzcv_reg [2];

    logic [1:0]     req_vec;
    logic [3:0]     alu_op_vec   [2];
    logic [2:0]     shift_op_vec [2];
    logic [DW-1:0]  a_vec        [2];
    logic [DW-1:0]  sd_vec       [2];
    logic [SNW-1:0] sn_vec       [2];
    logic [1:0]     cv_vec       [2];
    logic           win_next;

    assign req_vec         = {req1, req0};
    assign alu_op_vec[0]   = alu_op0;
    assign alu_op_vec[1]   = alu_op1;
    assign shift_op_vec[0] = shift_op0;
    assign shift_op_vec[1] = shift_op1;
    assign a_vec[0]        = a0;
    assign a_vec[1]        = a1;
    assign sd_vec[0]       = sd0;
    assign sd_vec[1]       = sd1;
    assign sn_vec[0]       = sn0;
    assign sn_vec[1]       = sn1;
    assign cv_vec[0]       = cv0;
    assign cv_vec[1]       = cv1;

    // Channel 1 wins alone, or on a tie when channel 0 was served last.
    always_comb begin
        win_next = 1'b0;
`ifdef ALU_ARB_CORE_PRIO_EN
        win_next = req1 & ~req0;
`else
        win_next = req1 & (~req0 | ~last_reg);
`endif
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg    <= IDLE;
            last_reg     <= 1'b1;
            owner_reg    <= 1'b0;
            gnt_reg      <= '0;
            done_reg     <= '0;
            alu_op_reg   <= '0;
            shift_op_reg <= '0;
            a_reg        <= '0;
            sd_reg       <= '0;
            sn_reg       <= '0;
            cv_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= '0;
                    if (|req_vec) begin
                        alu_op_reg   <= alu_op_vec[win_next];
                        shift_op_reg <= shift_op_vec[win_next];
                        a_reg        <= a_vec[win_next];
                        sd_reg       <= sd_vec[win_next];
                        sn_reg       <= sn_vec[win_next];
                        cv_reg       <= cv_vec[win_next];
                        gnt_reg      <= 2'b01 << win_next;
                        last_reg     <= win_next;
                        owner_reg    <= win_next;
                        state_reg    <= EXEC;
                    end else begin
                        gnt_reg <= '0;
                    end
                end
                EXEC: begin
                    // Requests are deliberately ignored here; the ALU operands stay put.
                    gnt_reg   <= '0;
                    done_reg  <= 2'b01 << owner_reg;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Each channel's result only moves when that channel owns the completing operation.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_result
            always_ff @(posedge clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    f_reg[gi]    <= '0;
                    nzcv_reg[gi] <= '0;
                end else if (state_reg == EXEC && owner_reg == 1'(gi)) begin
                    f_reg[gi]    <= F_New;
                    nzcv_reg[gi] <= NZCV_New;
                end
            end
        end
    endgenerate

    assign gnt0       = gnt_reg[0];
    assign gnt1       = gnt_reg[1];
    assign done0      = done_reg[0];
    assign done1      = done_reg[1];
    assign f0         = f_reg[0];
    assign f1         = f_reg[1];
    assign nzcv0      = nzcv_reg[0];
    assign nzcv1      = nzcv_reg[1];
    assign ALU_OP     = alu_op_reg;
    assign SHIFT_OP   = shift_op_reg;
    assign A          = a_reg;
    assign Shift_Data = sd_reg;
    assign Shift_Num  = sn_reg;
    assign CF         = cv_reg[1];
    assign VF         = cv_reg[0];
    assign busy       = (state_reg == EXEC);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: small ALU_Shift model on the shared port, result scoreboard on done pulses.
module tb_alu_arbiter;
    localparam int DW  = 32;
    localparam int SNW = 8;

    logic           clk = 1'b0;
    logic           Rst_n = 1'b1;
    logic           req0 = 0, req1 = 0;
    logic [3:0]     alu_op0 = '0, alu_op1 = '0;
    logic [2:0]     shift_op0 = '0, shift_op1 = '0;
    logic [DW-1:0]  a0 = '0, a1 = '0, sd0 = '0, sd1 = '0;
    logic [SNW-1:0] sn0 = '0, sn1 = '0;
    logic [1:0]     cv0 = '0, cv1 = '0;
    logic           gnt0, gnt1, done0, done1, busy, CF, VF;
    logic [DW-1:0]  f0, f1, A, Shift_Data, F_New;
    logic [3:0]     nzcv0, nzcv1, ALU_OP, NZCV_New;
    logic [2:0]     SHIFT_OP;
    logic [SNW-1:0] Shift_Num;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic          ch;
        logic [DW-1:0] f;
        logic [3:0]    nzcv;
    } exp_t;
    exp_t exp_q[$];
    exp_t sb_e;

    always #5 clk = ~clk;

    alu_arbiter #(.DW(DW), .SNW(SNW)) dut (
        .clk(clk), .Rst_n(Rst_n),
        .req0(req0), .alu_op0(alu_op0), .shift_op0(shift_op0), .a0(a0), .sd0(sd0), .sn0(sn0), .cv0(cv0),
        .gnt0(gnt0), .done0(done0), .f0(f0), .nzcv0(nzcv0),
        .req1(req1), .alu_op1(alu_op1), .shift_op1(shift_op1), .a1(a1), .sd1(sd1), .sn1(sn1), .cv1(cv1),
        .gnt1(gnt1), .done1(done1), .f1(f1), .nzcv1(nzcv1),
        .ALU_OP(ALU_OP), .SHIFT_OP(SHIFT_OP), .A(A), .Shift_Data(Shift_Data), .Shift_Num(Shift_Num),
        .CF(CF), .VF(VF), .F_New(F_New), .NZCV_New(NZCV_New), .busy(busy)
    );

    // Minimal ALU_Shift: LSL shifter feeding ADD/SUB, AND otherwise.
    logic [DW-1:0] shd;
    logic [DW:0]   sum;
    always_comb begin
        shd      = (SHIFT_OP == 3'b000) ? (Shift_Data << Shift_Num) : Shift_Data;
        sum      = '0;
        F_New    = '0;
        NZCV_New = '0;
        case (ALU_OP)
            4'b0100: begin
                sum      = {1'b0, A} + {1'b0, shd};
                F_New    = sum[DW-1:0];
                NZCV_New = {F_New[DW-1], F_New == '0, sum[DW],
                            (A[DW-1] == shd[DW-1]) && (F_New[DW-1] != A[DW-1])};
            end
            4'b0010: begin
                sum      = {1'b0, A} + {1'b0, ~shd} + 33'd1;
                F_New    = sum[DW-1:0];
                NZCV_New = {F_New[DW-1], F_New == '0, sum[DW],
                            (A[DW-1] != shd[DW-1]) && (F_New[DW-1] != A[DW-1])};
            end
            default: begin
                F_New    = A & shd;
                NZCV_New = {F_New[DW-1], F_New == '0, CF, VF};
            end
        endcase
    end

    logic any_out;
    assign any_out = |{gnt0, gnt1, done0, done1, busy, f0, f1, nzcv0, nzcv1,
                       ALU_OP, SHIFT_OP, A, Shift_Data, Shift_Num, CF, VF};

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (Rst_n && (done0 || done1)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_done: done0=%0b done1=%0b but no result pending", done0, done1);
            end else begin
                sb_e = exp_q.pop_front();
                if (done0 && done1) begin
                    n_fail++;
                    $display("FAIL sb_double_done: done0 and done1 both high, required only ch%0d", sb_e.ch);
                end else if ({done1, done1 ? f1 : f0, done1 ? nzcv1 : nzcv0} !== {sb_e.ch, sb_e.f, sb_e.nzcv}) begin
                    n_fail++;
                    $display("FAIL sb_result: got ch%0d f=%h nzcv=%b, required ch%0d f=%h nzcv=%b",
                             done1, done1 ? f1 : f0, done1 ? nzcv1 : nzcv0, sb_e.ch, sb_e.f, sb_e.nzcv);
                end else begin
                    $display("txn ch%0d f=%h nzcv=%b ok", sb_e.ch, sb_e.f, sb_e.nzcv);
                end
            end
        end
    end

    task automatic drive_ch(input int ch, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] sd);
        if (ch == 0) begin
            req0 = 1; alu_op0 = op; shift_op0 = 3'b000; a0 = a; sd0 = sd; sn0 = '0; cv0 = '0;
        end else begin
            req1 = 1; alu_op1 = op; shift_op1 = 3'b000; a1 = a; sd1 = sd; sn1 = '0; cv1 = '0;
        end
    endtask

    task automatic do_reset();
        req0 = 0; req1 = 0;
        #1 Rst_n = 0;
        repeat (2) @(negedge clk);
        Rst_n = 1;
    endtask

    task automatic test_reset();
        req0 = 0; req1 = 0;
        #1 Rst_n = 0;
        @(negedge clk);
        n_checks++;
        if (any_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: some output nonzero (busy=%0b A=%h f0=%h), required all 0", busy, A, f0);
        end
        Rst_n = 1;
        @(negedge clk);
        n_checks++;
        if (any_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: outputs moved with no request (busy=%0b gnt=%b%b), required all 0", busy, gnt1, gnt0);
        end
    endtask

    task automatic test_single_add();
        @(negedge clk);
        drive_ch(0, 4'b0100, 32'd5, 32'd3);
        exp_q.push_back('{ch: 1'b0, f: 32'd8, nzcv: 4'b0000});
        @(negedge clk);
        n_checks++;
        if ({gnt0, gnt1, busy, done0} !== 4'b1010) begin
            n_fail++;
            $display("FAIL add_grant: {gnt0,gnt1,busy,done0}=%b, required 1010", {gnt0, gnt1, busy, done0});
        end
        n_checks++;
        if ({ALU_OP, A, Shift_Data} !== {4'b0100, 32'd5, 32'd3}) begin
            n_fail++;
            $display("FAIL add_alu_port: op=%b A=%h sd=%h, required 0100 5 3", ALU_OP, A, Shift_Data);
        end
        req0 = 0;
        @(negedge clk);
        n_checks++;
        if ({gnt0, busy, done0, f0, nzcv0} !== {3'b001, 32'd8, 4'b0000}) begin
            n_fail++;
            $display("FAIL add_done: gnt0=%0b busy=%0b done0=%0b f0=%h nzcv0=%b, required 0 0 1 8 0000", gnt0, busy, done0, f0, nzcv0);
        end
        n_checks++;
        if ({f1, nzcv1} !== '0) begin
            n_fail++;
            $display("FAIL add_other_ch: f1=%h nzcv1=%b, required 0", f1, nzcv1);
        end
        @(negedge clk);
        n_checks++;
        if ({done0, f0, A} !== {1'b0, 32'd8, 32'd5}) begin
            n_fail++;
            $display("FAIL add_hold: done0=%0b f0=%h A=%h, required 0 8 5", done0, f0, A);
        end
    endtask

    task automatic test_overflow();
        @(negedge clk);
        drive_ch(1, 4'b0100, 32'h7FFF_FFFF, 32'd1);
        exp_q.push_back('{ch: 1'b1, f: 32'h8000_0000, nzcv: 4'b1001});
        @(negedge clk);
        n_checks++;
        if ({gnt0, gnt1, busy, done1} !== 4'b0110) begin
            n_fail++;
            $display("FAIL ovf_grant: {gnt0,gnt1,busy,done1}=%b, required 0110", {gnt0, gnt1, busy, done1});
        end
        req1 = 0;
        @(negedge clk);
        n_checks++;
        if ({done1, f1, nzcv1} !== {1'b1, 32'h8000_0000, 4'b1001}) begin
            n_fail++;
            $display("FAIL ovf_result: done1=%0b f1=%h nzcv1=%b, required 1 80000000 1001", done1, f1, nzcv1);
        end
        n_checks++;
        if ({f0, nzcv0} !== {32'd8, 4'b0000}) begin
            n_fail++;
            $display("FAIL ovf_other_ch: f0=%h nzcv0=%b, required 8 0000", f0, nzcv0);
        end
    endtask

    task automatic test_zero_result();
        @(negedge clk);
        drive_ch(0, 4'b0010, 32'd3, 32'd3);
        exp_q.push_back('{ch: 1'b0, f: 32'd0, nzcv: 4'b0110});
        @(negedge clk);
        req0 = 0;
        @(negedge clk);
        n_checks++;
        if ({done0, f0, nzcv0} !== {1'b1, 32'd0, 4'b0110}) begin
            n_fail++;
            $display("FAIL zero_result: done0=%0b f0=%h nzcv0=%b, required 1 0 0110", done0, f0, nzcv0);
        end
        drive_ch(1, 4'b0100, 32'd2, 32'd2);
        exp_q.push_back('{ch: 1'b1, f: 32'd4, nzcv: 4'b0000});
        @(negedge clk);
        req1 = 0;
        @(negedge clk);
        n_checks++;
        if ({done1, f1, f0, nzcv0} !== {1'b1, 32'd4, 32'd0, 4'b0110}) begin
            n_fail++;
            $display("FAIL zero_isolation: done1=%0b f1=%h f0=%h nzcv0=%b, required 1 4 0 0110", done1, f1, f0, nzcv0);
        end
    endtask

    task automatic test_alternate();
        logic [1:0] exp_gnt;
        logic       g_ch;
        do_reset();
        @(negedge clk);
        drive_ch(0, 4'b0100, 32'd10, 32'd1);
        drive_ch(1, 4'b0010, 32'd10, 32'd4);
        for (int g = 0; g < 4; g++) begin
`ifdef ALU_ARB_CORE_PRIO_EN
            g_ch = 1'b0;
`else
            g_ch = g[0];
`endif
            if (g_ch) exp_q.push_back('{ch: 1'b1, f: 32'd6, nzcv: 4'b0010});
            else      exp_q.push_back('{ch: 1'b0, f: 32'd11, nzcv: 4'b0000});
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
`ifdef ALU_ARB_CORE_PRIO_EN
            g_ch = 1'b0;
`else
            g_ch = ((i - 1) / 2) % 2 == 1;
`endif
            exp_gnt = (i % 2 == 1) ? (g_ch ? 2'b10 : 2'b01) : 2'b00;
            n_checks++;
            if ({gnt1, gnt0, busy} !== {exp_gnt, i % 2 == 1}) begin
                n_fail++;
                $display("FAIL alternate_c%0d: {gnt1,gnt0,busy}=%b, required %b", i, {gnt1, gnt0, busy}, {exp_gnt, i % 2 == 1});
            end
        end
        req0 = 0; req1 = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        drive_ch(1, 4'b0100, 32'd9, 32'd9);
        @(negedge clk);
        n_checks++;
        if ({gnt1, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL abort_setup: gnt1=%0b busy=%0b, required 1 1", gnt1, busy);
        end
        #2 Rst_n = 0;
        req1 = 0;
        #1;
        n_checks++;
        if (any_out !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: busy=%0b gnt1=%0b A=%h f0=%h, required all 0", busy, gnt1, A, f0);
        end
        @(negedge clk);
        Rst_n = 1;
        @(negedge clk);
        n_checks++;
        if ({done1, busy, f1} !== '0) begin
            n_fail++;
            $display("FAIL abort_no_done: done1=%0b busy=%0b f1=%h, required 0", done1, busy, f1);
        end
        drive_ch(0, 4'b0100, 32'd1, 32'd1);
        exp_q.push_back('{ch: 1'b0, f: 32'd2, nzcv: 4'b0000});
        @(negedge clk);
        n_checks++;
        if ({gnt0, gnt1, busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL abort_regrant: {gnt0,gnt1,busy}=%b, required 101", {gnt0, gnt1, busy});
        end
        req0 = 0;
        @(negedge clk);
        n_checks++;
        if ({done0, f0} !== {1'b1, 32'd2}) begin
            n_fail++;
            $display("FAIL abort_result: done0=%0b f0=%h, required 1 2", done0, f0);
        end
    endtask

    task automatic test_early_drop();
        @(negedge clk);
        #1 drive_ch(1, 4'b0100, 32'd7, 32'd7);
        #2 req1 = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({gnt1, busy, done1} !== 3'b000) begin
                n_fail++;
                $display("FAIL early_drop_c%0d: {gnt1,busy,done1}=%b, required 000", i, {gnt1, busy, done1});
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_add();
        test_overflow();
        test_zero_result();
        test_alternate();
        test_reset_abort();
        test_early_drop();
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d results never completed, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
